// File: rtl/axi4lite_cmd_master.sv
// Turns a valid/ready command into one AXI4-Lite transaction at a time.
// Define AXI_TIMEOUT_EN to enable the per-transaction watchdog.
module axi4lite_cmd_master #(
   parameter int C_M_AXI_ADDR_WIDTH = 2,
   parameter int C_M_AXI_DATA_WIDTH = 8,
   parameter int C_TIMEOUT_CYCLES   = 16
) (
   input  logic                              m_axi_aclk,
   input  logic                              m_axi_aresetn,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic                              cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                        rsp_resp,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic                              m_axi_awvalid,
   input  logic                              m_axi_awready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                              m_axi_wvalid,
   input  logic                              m_axi_wready,
   input  logic [1:0]                        m_axi_bresp,
   input  logic                              m_axi_bvalid,
   output logic                              m_axi_bready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic                              m_axi_arvalid,
   input  logic                              m_axi_arready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                        m_axi_rresp,
   input  logic                              m_axi_rvalid,
   output logic                              m_axi_rready
);

   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;
   localparam int SW = C_M_AXI_DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_WR_B,
      S_RD_A,
      S_RD_D,
      S_RSP
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [SW-1:0]   wstrb_q, wstrb_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [1:0]      resp_q, resp_d;
   logic            awvalid_q, awvalid_d;
   logic            wvalid_q, wvalid_d;
   logic            bready_q, bready_d;
   logic            arvalid_q, arvalid_d;
   logic            rready_q, rready_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            aw_done_q, aw_done_d;
   logic            w_done_q, w_done_d;
   logic            b_seen_q, b_seen_d;

   logic cmd_fire;
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic aw_dn, w_dn, b_sn;
   logic busy;
   logic to_hit;

   assign cmd_ready = (state_q == S_IDLE) & m_axi_aresetn;
   assign cmd_fire  = cmd_valid & cmd_ready;

   assign aw_hs = awvalid_q & m_axi_awready;
   assign w_hs  = wvalid_q & m_axi_wready;
   assign b_hs  = bready_q & m_axi_bvalid;
   assign ar_hs = arvalid_q & m_axi_arready;
   assign r_hs  = rready_q & m_axi_rvalid;

   assign aw_dn = aw_done_q | aw_hs;
   assign w_dn  = w_done_q | w_hs;
   assign b_sn  = b_seen_q | b_hs;

   assign busy = (state_q == S_WR) | (state_q == S_WR_B) |
                 (state_q == S_RD_A) | (state_q == S_RD_D);

`ifdef AXI_TIMEOUT_EN
   logic [7:0] cnt_q;

   // Abort lands on the edge where the counter would reach the limit.
   assign to_hit = busy & (cnt_q == 8'(C_TIMEOUT_CYCLES - 1));

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn)
         cnt_q <= '0;
      else if (cmd_fire)
         cnt_q <= '0;
      else if (busy)
         cnt_q <= cnt_q + 8'd1;
   end
`else
   logic unused_timeout;

   assign to_hit = 1'b0;
   assign unused_timeout = ^8'(C_TIMEOUT_CYCLES);
`endif

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rdata_d     = rdata_q;
      resp_d      = resp_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      b_seen_d    = b_seen_q;

      unique case (state_q)
         S_IDLE: begin
            if (cmd_fire) begin
               addr_d    = cmd_addr;
               rdata_d   = '0;
               resp_d    = 2'b00;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               b_seen_d  = 1'b0;
               if (cmd_write) begin
                  wdata_d   = cmd_wdata;
                  wstrb_d   = cmd_wstrb;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  bready_d  = 1'b1;
                  state_d   = S_WR;
               end else begin
                  wdata_d   = '0;
                  wstrb_d   = '0;
                  arvalid_d = 1'b1;
                  rready_d  = 1'b1;
                  state_d   = S_RD_A;
               end
            end
         end
         S_WR: begin
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            if (b_hs)  resp_d    = m_axi_bresp;
            aw_done_d = aw_dn;
            w_done_d  = w_dn;
            b_seen_d  = b_sn;
            // The slave may pulse B early, so B is tracked separately.
            if (aw_dn & w_dn) begin
               if (b_sn) begin
                  bready_d    = 1'b0;
                  rsp_valid_d = 1'b1;
                  state_d     = S_RSP;
               end else begin
                  state_d = S_WR_B;
               end
            end
         end
         S_WR_B: begin
            if (b_hs) begin
               resp_d      = m_axi_bresp;
               b_seen_d    = 1'b1;
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = S_RSP;
            end
         end
         S_RD_A: begin
            if (ar_hs) begin
               arvalid_d = 1'b0;
               if (r_hs) begin
                  rdata_d     = m_axi_rdata;
                  resp_d      = m_axi_rresp;
                  rready_d    = 1'b0;
                  rsp_valid_d = 1'b1;
                  state_d     = S_RSP;
               end else begin
                  state_d = S_RD_D;
               end
            end
         end
         S_RD_D: begin
            if (r_hs) begin
               rdata_d     = m_axi_rdata;
               resp_d      = m_axi_rresp;
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = S_RSP;
            end
         end
         S_RSP: begin
            if (rsp_valid_q & rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (to_hit) begin
         awvalid_d   = 1'b0;
         wvalid_d    = 1'b0;
         bready_d    = 1'b0;
         arvalid_d   = 1'b0;
         rready_d    = 1'b0;
         rdata_d     = '0;
         resp_d      = 2'b11;
         rsp_valid_d = 1'b1;
         state_d     = S_RSP;
      end
   end

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rdata_q     <= '0;
         resp_q      <= 2'b00;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         b_seen_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rdata_q     <= rdata_d;
         resp_q      <= resp_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         b_seen_q    <= b_seen_d;
      end
   end

   assign m_axi_awaddr  = addr_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rdata_q;
   assign rsp_resp      = resp_q;

endmodule
